// File: rtl/key_conditioner.sv
// key_conditioner
//
// Per-key push-button conditioner: a two-flop synchroniser, a counter-based
// debounce FSM per key, and registered level / single-cycle edge outputs.
// Every key channel is independent and runs in parallel on clk.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   When defined, a key held in PRESSED emits extra key_press pulses
//   HOLD_CYCLES edges after the accepted press, then every REPEAT_CYCLES.
//   When undefined, no repeat logic is built and HOLD_CYCLES and
//   REPEAT_CYCLES have no effect beyond the legality check.
//
// Parameters:
//   NUM_KEYS        number of key channels
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a change (>=1)
//   HOLD_CYCLES     cycles from accepted press to first repeat pulse (>=1)
//   REPEAT_CYCLES   cycles between subsequent repeat pulses (>=1)
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   rst         synchronous active-high reset
//   key_n       raw asynchronous keys, active-low (0 = pressed)
//   key_level   debounced key state, 1 = pressed
//   key_press   one-cycle pulse on an accepted press (and on auto-repeat)
//   key_release one-cycle pulse on an accepted release
//
// Each channel's FSM state is held in gen_key[i].state_q for observation.

module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam bit CFG_OK = (NUM_KEYS >= 1) && (DEBOUNCE_CYCLES >= 1) &&
                            (HOLD_CYCLES >= 1) && (REPEAT_CYCLES >= 1);

    if (!CFG_OK) begin : g_cfg_error
        $error("key_conditioner: illegal parameter value");
    end

    // Two-flop synchroniser; reset loads the released level.
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : gen_key
        key_state_t    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          rep_pulse;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!sync2[i]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sync2[i]) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to low keeps the key pressed silently.
                    if (!sync2[i]) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

`ifdef KEY_AUTOREPEAT_EN
        localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
        localparam int RW   = $clog2(RMAX) + 1;
        localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
        localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          rep_q, rep_d;  // first repeat already issued

        // Counter sits at zero outside PRESSED/RELEASE_WAIT, which covers
        // both the clear on entering PRESSED and the clear on release.
        // It only advances on cycles that stay in PRESSED, so it is frozen
        // across RELEASE_WAIT and resumes after a bounce.
        always_comb begin
            rcnt_d    = rcnt_q;
            rep_d     = rep_q;
            rep_pulse = 1'b0;
            if (state_q != PRESSED && state_q != RELEASE_WAIT) begin
                rcnt_d = '0;
                rep_d  = 1'b0;
            end else if (state_q == PRESSED && !sync2[i]) begin
                if (rcnt_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
                    rep_pulse = 1'b1;
                    rcnt_d    = '0;
                    rep_d     = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rcnt_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                rcnt_q <= rcnt_d;
                rep_q  <= rep_d;
            end
        end
`else
        assign rep_pulse = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d | rep_pulse;
                release_q <= release_d;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with NUM_KEYS=4, DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=10, REPEAT_CYCLES=5. Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point, so "edge N" below means the
// values observed just after rising edge N.

module tb_key_conditioner;

    localparam int NK = 4;
    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 5;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    int errors;
    int checks;
    int cyc;
    int press_cnt  [NK];
    int press_edge [NK];
    int rel_cnt    [NK];
    int rel_edge   [NK];
    int overlap;
    int e0;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One clock edge, then record pulse activity seen after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NK; k++) begin
            if (key_press[k]) begin
                press_cnt[k]++;
                press_edge[k] = cyc;
            end
            if (key_release[k]) begin
                rel_cnt[k]++;
                rel_edge[k] = cyc;
            end
            if (key_press[k] && key_release[k]) overlap++;
        end
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) begin
            press_cnt[k]  = 0;
            press_edge[k] = -1;
            rel_cnt[k]    = 0;
            rel_edge[k]   = -1;
        end
    endtask

    task automatic idle_gap();
        ticks($urandom_range(3, 6));
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        overlap = 0;
        clear_counts();
        rst   = 1'b1;
        key_n = '1;
        #1;
        ticks(3);
        check("reset_level",   32'(key_level),   32'h0);
        check("reset_press",   32'(key_press),   32'h0);
        check("reset_release", 32'(key_release), 32'h0);
        rst = 1'b0;
        idle_gap();

        // Clean press on key 0: pulse in the cycle after edge 6.
        clear_counts();
        key_n[0] = 1'b0;
        e0 = cyc + 1;
        ticks(6);
        check("clean_level_pre", 32'(key_level), 32'h0);
        check("clean_press_pre", 32'(key_press), 32'h0);
        tick();
        check("clean_press_e6", 32'(key_press), 32'b0001);
        check("clean_level_e6", 32'(key_level), 32'b0001);
        tick();
        check("clean_press_e7", 32'(key_press), 32'b0000);
        check("clean_level_e7", 32'(key_level), 32'b0001);
        check("clean_edge", 32'(press_edge[0]), 32'(e0 + 6));

        // Release with bounce on key 0: high 2, low 1, then high.
        clear_counts();
        key_n[0] = 1'b1;
        ticks(2);
        key_n[0] = 1'b0;
        tick();
        key_n[0] = 1'b1;
        e0 = cyc + 1;
        ticks(6);
        check("relb_level_hold", 32'(key_level), 32'b0001);
        check("relb_no_early",   32'(rel_cnt[0]), 32'd0);
        tick();
        check("relb_release", 32'(key_release), 32'b0001);
        check("relb_level0",  32'(key_level),   32'b0000);
        ticks(4);
        check("relb_count", 32'(rel_cnt[0]),  32'd1);
        check("relb_edge",  32'(rel_edge[0]), 32'(e0 + 6));
        check("relb_press", 32'(press_cnt[0]), 32'd0);

        // Bounce on press, key 1: low 2, high 1, then held low.
        idle_gap();
        clear_counts();
        key_n[1] = 1'b0;
        ticks(2);
        key_n[1] = 1'b1;
        tick();
        key_n[1] = 1'b0;
        e0 = cyc + 1;
        ticks(10);
        check("pb_count", 32'(press_cnt[1]),  32'd1);
        check("pb_edge",  32'(press_edge[1]), 32'(e0 + 6));
        check("pb_level", 32'(key_level),     32'b0010);
        key_n[1] = 1'b1;
        ticks(8);
        check("pb_rel_count", 32'(rel_cnt[1]), 32'd1);

        // Simultaneous keys 3 and 2.
        idle_gap();
        clear_counts();
        key_n[3:2] = 2'b00;
        ticks(7);
        check("sim_press", 32'(key_press), 32'b1100);
        check("sim_level", 32'(key_level), 32'b1100);
        key_n[3:2] = 2'b11;
        ticks(7);
        check("sim_release", 32'(key_release), 32'b1100);
        check("sim_level0",  32'(key_level),   32'b0000);

        // Glitch of a single cycle on key 2 is rejected.
        idle_gap();
        clear_counts();
        key_n[2] = 1'b0;
        tick();
        key_n[2] = 1'b1;
        ticks(10);
        check("glitch_press", 32'(press_cnt[2]), 32'd0);
        check("glitch_level", 32'(key_level),    32'b0000);

        // Reset during PRESS_WAIT on key 0; key stays held.
        idle_gap();
        clear_counts();
        key_n[0] = 1'b0;
        ticks(4);
        rst = 1'b1;
        tick();
        check("rstpw_level", 32'(key_level),   32'h0);
        check("rstpw_press", 32'(key_press),   32'h0);
        rst = 1'b0;
        e0 = cyc + 1;
        ticks(8);
        check("rstpw_count", 32'(press_cnt[0]),  32'd1);
        check("rstpw_edge",  32'(press_edge[0]), 32'(e0 + 6));

        // Reset while PRESSED: no release, fresh press afterwards.
        clear_counts();
        check("rsth_level_pre", 32'(key_level), 32'b0001);
        rst = 1'b1;
        tick();
        check("rsth_level",   32'(key_level),   32'h0);
        check("rsth_release", 32'(key_release), 32'h0);
        rst = 1'b0;
        e0 = cyc + 1;
        ticks(7);
        check("rsth_edge",    32'(press_edge[0]), 32'(e0 + 6));
        check("rsth_rel_cnt", 32'(rel_cnt[0]),    32'd0);

        // Key 0 stays held for 40 more cycles after its accepted press at e0+6.
        ticks(40);
`ifdef KEY_AUTOREPEAT_EN
        check("hold_count", 32'(press_cnt[0]),  32'd8);
        check("hold_last",  32'(press_edge[0]), 32'(e0 + 6 + 40));
`else
        check("hold_count", 32'(press_cnt[0]),  32'd1);
        check("hold_last",  32'(press_edge[0]), 32'(e0 + 6));
`endif
        check("hold_level", 32'(key_level), 32'b0001);
        key_n[0] = 1'b1;
        e0 = cyc + 1;
        ticks(8);
        check("hold_release", 32'(rel_edge[0]), 32'(e0 + 6));
        check("no_overlap",   32'(overlap),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
